// File: rtl/pc_sequencer_pkg.sv
// Shared op-class and state encodings for the program-counter sequencer and its decoder.
// Also holds the active_edge selector values.
package pc_sequencer_pkg;

  localparam logic POS_EDGE = 1'b1;
  localparam logic NEG_EDGE = 1'b0;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRZ  = 3'd2,
    OP_CALL = 3'd3,
    OP_RTRN = 3'd4,
    OP_HALT = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_stack_depth_counter.sv
// Saturating up/down counter mirroring the instruction stack occupancy (0..2^addr_width).
// Only exists when PC_STACK_GUARD_EN is defined.
`ifdef PC_STACK_GUARD_EN
module stack_depth_counter #(
  parameter int addr_width = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned DEPTH_MAX = 1 << addr_width;
  localparam logic [addr_width:0] DEPTH_ONE = {{addr_width{1'b0}}, 1'b1};

  logic [addr_width:0] depth_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else if (inc_i && !dec_i && !full_o) begin
      depth_q <= depth_q + DEPTH_ONE;
    end else if (dec_i && !inc_i && !empty_o) begin
      depth_q <= depth_q - DEPTH_ONE;
    end
  end

  assign full_o  = (depth_q == DEPTH_MAX[addr_width:0]);
  assign empty_o = (depth_q == '0);

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, decodes control-flow ops, drives call/rtrn into the stack.
// Optional stack depth guard (overflow/underflow -> HALT) enabled by defining PC_STACK_GUARD_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int   addr_width  = 4,
  parameter int   data_width  = 16,
  parameter logic active_edge = POS_EDGE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            i_op,
  input  logic [data_width-1:0] i_target,
  input  logic                  i_cond,
  input  logic                  i_stall,
  input  logic [data_width-1:0] i_Stack,
  output logic [data_width-1:0] o_PC,
  output logic [data_width-1:0] o_Stack_PC,
  output logic                  o_call,
  output logic                  o_rtrn,
  output logic                  o_halted,
  output logic                  o_ovf,
  output logic                  o_unf
);

  localparam logic [data_width-1:0] PC_INC = {{(data_width-1){1'b0}}, 1'b1};

  logic                  clk_int;
  state_e                state_q;
  logic [data_width-1:0] pc_q;
  logic                  halted_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  stk_full;
  logic                  stk_empty;
  logic                  run_go;
  logic                  call_req;
  logic                  rtrn_req;

  // All state moves on the selected edge; the stack must be clocked the same way.
  assign clk_int = (active_edge == NEG_EDGE) ? ~clk : clk;

  assign run_go   = (state_q == ST_RUN) && !i_stall && !rst;
  assign call_req = run_go && (i_op == OP_CALL);
  assign rtrn_req = run_go && (i_op == OP_RTRN);
  assign o_call   = call_req && !stk_full;
  assign o_rtrn   = rtrn_req && !stk_empty;

`ifdef PC_STACK_GUARD_EN
  stack_depth_counter #(
    .addr_width(addr_width)
  ) u_depth (
    .clk    (clk_int),
    .rst    (rst),
    .inc_i  (o_call),
    .dec_i  (o_rtrn),
    .full_o (stk_full),
    .empty_o(stk_empty)
  );
`else
  assign stk_full  = 1'b0;
  assign stk_empty = 1'b0;
`endif

  always_ff @(posedge clk_int) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!i_stall) begin
            case (i_op)
              OP_JMP:  pc_q <= i_target;
              OP_BRZ:  pc_q <= i_cond ? i_target : pc_q + PC_INC;
              OP_CALL: begin
                if (stk_full) begin
                  ovf_q    <= 1'b1;
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
                end else begin
                  pc_q <= i_target;
                end
              end
              OP_RTRN: begin
                if (stk_empty) begin
                  unf_q    <= 1'b1;
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
                end else begin
                  state_q <= ST_RET_WAIT;
                end
              end
              OP_HALT: begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
              end
              default: pc_q <= pc_q + PC_INC;
            endcase
          end
        end
        // Stack output is valid one cycle after the pop; op and stall are ignored here.
        ST_RET_WAIT: begin
          pc_q    <= i_Stack;
          state_q <= ST_RUN;
        end
        default: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_PC       = pc_q;
  assign o_Stack_PC = pc_q;
  assign o_halted   = halted_q;
  assign o_ovf      = ovf_q;
  assign o_unf      = unf_q;

endmodule
